calc1_port_scheduler: RTL and testbench

//  Front-end scheduler for the calc1 shared ALU. Accepts two-cycle commands from

---
 rtl/calc1_port_scheduler.sv | 127 ++++++++++++
 tb/tb_calc1_port_scheduler.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/calc1_port_scheduler.sv
// calc1_port_scheduler: queues one two-cycle command per port and grants the shared ALU round-robin
// Ports: c_clk/reset (sync, active-high); req_cmd_in/req_data_in per-port command and operands;
// out_resp/out_data per-port one-cycle response; alu_valid/alu_cmd/alu_op1/alu_op2 issue to ALU;
// alu_done/alu_resp/alu_data result from ALU.
module calc1_port_scheduler #(
  parameter int NPORTS = 4,
  parameter int DW = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                   c_clk,
  input  logic                   reset,
  input  logic [4*NPORTS-1:0]    req_cmd_in,
  input  logic [DW*NPORTS-1:0]   req_data_in,
  output logic [2*NPORTS-1:0]    out_resp,
  output logic [DW*NPORTS-1:0]   out_data,
  output logic                   alu_valid,
  output logic [3:0]             alu_cmd,
  output logic [DW-1:0]          alu_op1,
  output logic [DW-1:0]          alu_op2,
  input  logic                   alu_done,
  input  logic [1:0]             alu_resp,
  input  logic [DW-1:0]          alu_data
);
  localparam int PW = NPORTS > 1 ? $clog2(NPORTS) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, OP2, ERR, PEND, BUSY, RESP} pst_e;
  typedef enum logic {FREE, WAIT} ast_e;
  pst_e pst_q [NPORTS];
  pst_e pst_d [NPORTS];
  logic [3:0] pcmd_q [NPORTS];
  logic [DW-1:0] pop1_q [NPORTS];
  logic [DW-1:0] pop2_q [NPORTS];
  logic [DW-1:0] pdat_q [NPORTS];
  logic [1:0] prsp_q [NPORTS];
  ast_e ast_q, ast_d;
  logic [PW-1:0] ptr_q, gnt_q, sel, idx;
  logic [CW-1:0] cnt_q;
  logic any, issue, fin;
  logic [1:0] fin_rsp;
  logic [DW-1:0] fin_dat;
  logic alu_valid_q;
  logic [3:0] alu_cmd_q;
  logic [DW-1:0] alu_op1_q, alu_op2_q;
  function automatic logic valid_cmd(input logic [3:0] c);
    return c inside {4'd1, 4'd2, 4'd5, 4'd6};
  endfunction
  assign alu_valid = alu_valid_q;
  assign alu_cmd = alu_cmd_q;
  assign alu_op1 = alu_op1_q;
  assign alu_op2 = alu_op2_q;
  // Round-robin pick: first PEND port at or after the pointer, wrapping.
  always_comb begin
    sel = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < NPORTS; i++) begin
      idx = PW'((int'(ptr_q) + i) % NPORTS);
      if (!any && pst_q[idx] == PEND) begin
        sel = idx;
        any = 1'b1;
      end
    end
    issue = ast_q == FREE && any;
    // A timed-out op completes like an ALU error with zero data.
    fin = ast_q == WAIT && (alu_done || cnt_q == CW'(TIMEOUT));
    fin_rsp = alu_done ? alu_resp : 2'd2;
    fin_dat = alu_done ? alu_data : '0;
    ast_d = issue ? WAIT : fin ? FREE : ast_q;
  end
  always_comb begin
    for (int p = 0; p < NPORTS; p++) begin
      pst_d[p] = pst_q[p];
      case (pst_q[p])
        IDLE: pst_d[p] = req_cmd_in[4*p+:4] != 4'd0 ? OP2 : IDLE;
        OP2:  pst_d[p] = valid_cmd(pcmd_q[p]) ? PEND : ERR;
        PEND: pst_d[p] = issue && sel == PW'(p) ? BUSY : PEND;
        BUSY: pst_d[p] = fin && gnt_q == PW'(p) ? RESP : BUSY;
        default: pst_d[p] = IDLE;
      endcase
      out_resp[2*p+:2] = pst_q[p] == RESP ? prsp_q[p] : pst_q[p] == ERR ? 2'd2 : 2'd0;
      out_data[DW*p+:DW] = pst_q[p] == RESP ? pdat_q[p] : '0;
    end
  end
  always_ff @(posedge c_clk) begin
    if (reset) begin
      for (int p = 0; p < NPORTS; p++) begin
        pst_q[p] <= IDLE;
        pcmd_q[p] <= '0;
        pop1_q[p] <= '0;
        pop2_q[p] <= '0;
        pdat_q[p] <= '0;
        prsp_q[p] <= '0;
      end
      ast_q <= FREE;
      ptr_q <= '0;
      gnt_q <= '0;
      cnt_q <= '0;
      alu_valid_q <= 1'b0;
      alu_cmd_q <= '0;
      alu_op1_q <= '0;
      alu_op2_q <= '0;
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        pst_q[p] <= pst_d[p];
        if (pst_q[p] == IDLE) begin
          pcmd_q[p] <= req_cmd_in[4*p+:4];
          pop1_q[p] <= req_data_in[DW*p+:DW];
        end
        if (pst_q[p] == OP2) pop2_q[p] <= req_data_in[DW*p+:DW];
        if (pst_q[p] == BUSY && pst_d[p] == RESP) begin
          prsp_q[p] <= fin_rsp;
          pdat_q[p] <= fin_dat;
        end
      end
      ast_q <= ast_d;
      alu_valid_q <= issue;
      cnt_q <= issue ? '0 : ast_q == WAIT ? cnt_q + 1'b1 : cnt_q;
      if (issue) begin
        gnt_q <= sel;
        ptr_q <= sel == PW'(NPORTS - 1) ? '0 : sel + 1'b1;
        alu_cmd_q <= pcmd_q[sel];
        alu_op1_q <= pop1_q[sel];
        alu_op2_q <= pop2_q[sel];
      end
    end
  end
endmodule

// File: tb/tb_calc1_port_scheduler.sv
// tb_calc1_port_scheduler: scoreboard bench for calc1_port_scheduler with a simple ALU model
module tb_calc1_port_scheduler;
  localparam int NP = 4;
  localparam int DW = 32;
  localparam int TO = 16;
  logic c_clk = 1'b0;
  logic reset = 1'b1;
  logic [4*NP-1:0] req_cmd_in = '0;
  logic [DW*NP-1:0] req_data_in = '0;
  logic [2*NP-1:0] out_resp;
  logic [DW*NP-1:0] out_data;
  logic alu_valid;
  logic [3:0] alu_cmd;
  logic [DW-1:0] alu_op1, alu_op2;
  logic alu_done = 1'b0;
  logic [1:0] alu_resp = '0;
  logic [DW-1:0] alu_data = '0;
  int cyc = 0, checks = 0, errors = 0, alu_lat = 2, mute_n = 0, t = 0;
  bit mon_en = 1'b0;
  typedef struct {int port; int rsp; logic [DW-1:0] data; int cyc;} resp_t;
  typedef struct {int cmd; logic [DW-1:0] a; logic [DW-1:0] b; int cyc;} iss_t;
  resp_t rq[$];
  iss_t iq[$];
  resp_t re;
  iss_t ie;
  calc1_port_scheduler #(.NPORTS(NP), .DW(DW), .TIMEOUT(TO)) dut (
    .c_clk(c_clk), .reset(reset), .req_cmd_in(req_cmd_in), .req_data_in(req_data_in),
    .out_resp(out_resp), .out_data(out_data), .alu_valid(alu_valid), .alu_cmd(alu_cmd),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_done(alu_done), .alu_resp(alu_resp),
    .alu_data(alu_data)
  );
  always #5 c_clk = ~c_clk;
  always @(posedge c_clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask
  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask
  task automatic set_port(input int p, input int c, input logic [DW-1:0] d);
    req_cmd_in[4*p+:4] = 4'(c);
    req_data_in[DW*p+:DW] = d;
  endtask
  task automatic send(input int p, input int c, input logic [DW-1:0] a, input logic [DW-1:0] b);
    set_port(p, c, a);
    tick();
    set_port(p, 0, b);
    tick();
    set_port(p, 0, 0);
  endtask
  task automatic exp_resp(input int p, input int r, input logic [DW-1:0] d, input int c);
    rq.push_back('{port: p, rsp: r, data: d, cyc: c});
  endtask
  task automatic exp_iss(input int c, input logic [DW-1:0] a, input logic [DW-1:0] b, input int cy);
    iq.push_back('{cmd: c, a: a, b: b, cyc: cy});
  endtask
  function automatic logic [DW-1:0] alu_f(input logic [3:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b);
    return c == 4'd1 ? a + b : c == 4'd2 ? a - b : c == 4'd5 ? a << b[4:0] : a >> b[4:0];
  endfunction
  always @(negedge c_clk) begin
    if (mon_en) begin
      for (int p = 0; p < NP; p++) begin
        if (out_resp[2*p+:2] != 2'd0) begin
          if (rq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: port %0d got resp %0d, expected none (cycle %0d)", p, out_resp[2*p+:2], cyc);
          end else begin
            re = rq.pop_front();
            chk("resp_port", 64'(p), 64'(re.port));
            chk("resp_code", 64'(out_resp[2*p+:2]), 64'(re.rsp));
            chk("resp_data", 64'(out_data[DW*p+:DW]), 64'(re.data));
            chk("resp_cycle", 64'(cyc), 64'(re.cyc));
          end
        end else chk("idle_data_zero", 64'(out_data[DW*p+:DW]), 64'd0);
      end
      if (alu_valid) begin
        if (iq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_issue: got cmd %0d, expected no alu_valid (cycle %0d)", alu_cmd, cyc);
        end else begin
          ie = iq.pop_front();
          chk("issue_cmd", 64'(alu_cmd), 64'(ie.cmd));
          chk("issue_op1", 64'(alu_op1), 64'(ie.a));
          chk("issue_op2", 64'(alu_op2), 64'(ie.b));
          chk("issue_cycle", 64'(cyc), 64'(ie.cyc));
        end
      end
    end
  end
  initial begin
    logic [3:0] c;
    logic [DW-1:0] a, b;
    int l;
    forever begin
      @(negedge c_clk);
      if (mon_en && alu_valid) begin
        if (mute_n > 0) mute_n--;
        else begin
          c = alu_cmd;
          a = alu_op1;
          b = alu_op2;
          l = alu_lat;
          repeat (l) @(posedge c_clk);
          #1;
          alu_done = 1'b1;
          alu_resp = 2'd1;
          alu_data = alu_f(c, a, b);
          @(posedge c_clk);
          #1;
          alu_done = 1'b0;
          alu_resp = '0;
          alu_data = '0;
        end
      end
    end
  end
  initial begin
    repeat (2) tick();
    chk("rst_out_resp", 64'(out_resp), 64'd0);
    chk("rst_out_data", 64'(out_data[63:0]), 64'd0);
    chk("rst_alu_valid", 64'(alu_valid), 64'd0);
    chk("rst_alu_cmd", 64'(alu_cmd), 64'd0);
    chk("rst_alu_ops", {alu_op1, alu_op2}, 64'd0);
    reset = 1'b0;
    tick();
    mon_en = 1'b1;
    // four ports at once: grants 0,1,2,3 spaced by L+2
    t = cyc;
    for (int p = 0; p < NP; p++) begin
      set_port(p, 1, DW'(10 * p + 1));
      exp_iss(1, DW'(10 * p + 1), DW'(p), t + 3 + 4 * p);
      exp_resp(p, 1, DW'(11 * p + 1), t + 6 + 4 * p);
    end
    tick();
    for (int p = 0; p < NP; p++) set_port(p, 0, DW'(p));
    tick();
    for (int p = 0; p < NP; p++) set_port(p, 0, 0);
    repeat (20) tick();
    // pointer back at 0, only ports 1 and 3 pending
    t = cyc;
    set_port(1, 1, 100);
    set_port(3, 2, 50);
    exp_iss(1, 100, 1, t + 3);
    exp_resp(1, 1, 101, t + 6);
    exp_iss(2, 50, 8, t + 7);
    exp_resp(3, 1, 42, t + 10);
    tick();
    set_port(1, 0, 1);
    set_port(3, 0, 8);
    tick();
    set_port(1, 0, 0);
    set_port(3, 0, 0);
    repeat (12) tick();
    // single add on port 0, L=2
    t = cyc;
    exp_iss(1, 3, 5, t + 3);
    exp_resp(0, 1, 8, t + 6);
    send(0, 1, 3, 5);
    repeat (8) tick();
    // invalid command on port 2: error at T+2, no ALU use
    t = cyc;
    exp_resp(2, 2, 0, t + 2);
    send(2, 4, 9, 9);
    repeat (5) tick();
    // ALU silent for port 0 -> timeout; port 1 queued behind it
    mute_n = 1;
    t = cyc;
    exp_iss(1, 1, 1, t + 3);
    exp_resp(0, 2, 0, t + 3 + TO + 1);
    exp_iss(5, 3, 2, t + TO + 5);
    exp_resp(1, 1, 12, t + TO + 8);
    set_port(0, 1, 1);
    tick();
    set_port(0, 0, 1);
    set_port(1, 5, 3);
    tick();
    set_port(0, 0, 0);
    set_port(1, 0, 2);
    tick();
    set_port(1, 0, 0);
    repeat (28) tick();
    // extra commands on port 1 while PEND and BUSY are ignored
    t = cyc;
    exp_iss(2, 20, 7, t + 3);
    exp_resp(1, 1, 13, t + 6);
    send(1, 2, 20, 7);
    set_port(1, 1, 99);
    tick();
    set_port(1, 0, 0);
    tick();
    set_port(1, 6, 77);
    tick();
    set_port(1, 0, 0);
    repeat (8) tick();
    // reset while the ALU op is outstanding; late alu_done must be ignored
    alu_lat = 4;
    t = cyc;
    exp_iss(1, 3, 4, t + 3);
    send(0, 1, 3, 4);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    alu_lat = 2;
    chk("mid_rst_out_resp", 64'(out_resp), 64'd0);
    chk("mid_rst_alu_valid", 64'(alu_valid), 64'd0);
    chk("mid_rst_alu_cmd", 64'(alu_cmd), 64'd0);
    chk("mid_rst_alu_ops", {alu_op1, alu_op2}, 64'd0);
    repeat (4) tick();
    t = cyc;
    exp_iss(6, 32'h80, 3, t + 3);
    exp_resp(3, 1, 32'h10, t + 6);
    send(3, 6, 32'h80, 3);
    repeat (10) tick();
    chk("resp_queue_empty", 64'(rq.size()), 64'd0);
    chk("issue_queue_empty", 64'(iq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
